// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Types and default constants shared by the SRAM arbiter files.
//   - arb_state_e : arbiter FSM state encoding (IDLE, SNES, AVR, GUARD)
//   - CNT_W       : width of the phase counter
//   - DEF_*       : default phase lengths in CLK cycles
package sram_arb_pkg;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned CNT_MAX         = 15;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_SNES_CYC    = 6;
  localparam int unsigned DEF_AVR_CYC     = 3;
  localparam int unsigned DEF_GUARD_CYC   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SNES  = 2'd1,
    ST_AVR   = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sram_arb_chk.sv
// sram_arb_chk
//   Elaboration-time legality check of the arbiter parameters. No ports.
//   Counters are 4 bits, so every cycle count must lie in 1..15 and the
//   synchroniser needs at least two stages.
module sram_arb_chk #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SNES_CYC    = 6,
  parameter int unsigned AVR_CYC     = 3,
  parameter int unsigned GUARD_CYC   = 1
) ();

  import sram_arb_pkg::*;

  if (SYNC_STAGES < 2 || SYNC_STAGES > CNT_MAX) begin : g_bad_sync
    $error("sram_arbiter: SYNC_STAGES must be in 2..15");
  end
  if (SNES_CYC < 1 || SNES_CYC > CNT_MAX) begin : g_bad_snes
    $error("sram_arbiter: SNES_CYC must be in 1..15");
  end
  if (AVR_CYC < 1 || AVR_CYC > CNT_MAX) begin : g_bad_avr
    $error("sram_arbiter: AVR_CYC must be in 1..15");
  end
  if (GUARD_CYC < 1 || GUARD_CYC > CNT_MAX) begin : g_bad_guard
    $error("sram_arbiter: GUARD_CYC must be in 1..15");
  end

endmodule

// File: rtl/sram_arb_sync.sv
// sram_arb_sync
//   Synchroniser chain for one asynchronous active-low SNES strobe, followed
//   by a falling-edge detector.
//   Ports:
//     clk_i   : system clock
//     rst_i   : asynchronous reset, active high (chain resets to 1 = idle)
//     async_i : asynchronous strobe input, active low
//     fall_o  : one-cycle pulse when the synchronised strobe goes 1 -> 0
module sram_arb_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser shift chain plus one flop holding the previous synchronised value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{1'b1}};
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Time-shares the cartridge SRAM bus between the SNES (priority) and the
//   AVR (background slots). Owns MODE, the SRAM strobes, AVR read data and
//   the AVR next-address pulse.
//   Optional feature macro: SRAM_ARB_AUTOINC_EN
//     defined   -> AVR_NEXTADDR_OUT pulses together with AVR_ACK
//     undefined -> AVR_NEXTADDR_OUT tied low
//   Ports:
//     CLK, RST          : clock, asynchronous active-high reset
//     SNES_RD, SNES_WR  : asynchronous active-low SNES strobes
//     AVR_REQ/WE/WDATA  : AVR request level, direction, write data
//     SRAM_DIN          : SRAM read data
//     MODE              : 0 = SNES phase, 1 = AVR phase
//     SRAM_OE_N/WE_N    : SRAM strobes, active low
//     SRAM_DOUT/DOE     : AVR write data and its bus drive enable
//     AVR_ACK           : one-cycle completion pulse
//     AVR_RDATA         : AVR read data, held until next ACK
//     AVR_NEXTADDR_OUT  : address counter step pulse
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned SNES_CYC    = DEF_SNES_CYC,
  parameter int unsigned AVR_CYC     = DEF_AVR_CYC,
  parameter int unsigned GUARD_CYC   = DEF_GUARD_CYC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SNES_RD,
  input  logic       SNES_WR,
  input  logic       AVR_REQ,
  input  logic       AVR_WE,
  input  logic [7:0] AVR_WDATA,
  input  logic [7:0] SRAM_DIN,
  output logic       MODE,
  output logic       SRAM_OE_N,
  output logic       SRAM_WE_N,
  output logic [7:0] SRAM_DOUT,
  output logic       SRAM_DOE,
  output logic       AVR_ACK,
  output logic [7:0] AVR_RDATA,
  output logic       AVR_NEXTADDR_OUT
);

  localparam logic [CNT_W-1:0] SNES_LAST  = CNT_W'(SNES_CYC - 1);
  localparam logic [CNT_W-1:0] AVR_LAST   = CNT_W'(AVR_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  sram_arb_chk #(
    .SYNC_STAGES(SYNC_STAGES),
    .SNES_CYC   (SNES_CYC),
    .AVR_CYC    (AVR_CYC),
    .GUARD_CYC  (GUARD_CYC)
  ) u_chk ();

  logic rd_fall_s;
  logic wr_fall_s;
  logic snes_fall_s;
  logic snes_req_s;
  logic snes_wr_s;

  sram_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk_i  (CLK),
    .rst_i  (RST),
    .async_i(SNES_RD),
    .fall_o (rd_fall_s)
  );

  sram_arb_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk_i  (CLK),
    .rst_i  (RST),
    .async_i(SNES_WR),
    .fall_o (wr_fall_s)
  );

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             snes_pend_q;
  logic             snes_wr_q;
  logic             avr_we_q;
  logic             mode_q;
  logic             oe_n_q;
  logic             we_n_q;
  logic             doe_q;
  logic [7:0]       dout_q;
  logic             ack_q;
  logic [7:0]       rdata_q;
`ifdef SRAM_ARB_AUTOINC_EN
  logic             nextaddr_q;
`endif

  // Effective SNES request: a pending access or an edge arriving this cycle.
  // Once pending, later edges merge and keep the recorded direction.
  always_comb begin
    snes_fall_s = rd_fall_s | wr_fall_s;
    snes_req_s  = snes_pend_q | snes_fall_s;
    if (snes_pend_q) begin
      snes_wr_s = snes_wr_q;
    end else begin
      snes_wr_s = wr_fall_s;
    end
  end

  // Arbiter FSM with phase counter, data latches and registered bus outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      snes_pend_q <= 1'b0;
      snes_wr_q   <= 1'b0;
      avr_we_q    <= 1'b0;
      mode_q      <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      doe_q       <= 1'b0;
      dout_q      <= 8'h00;
      ack_q       <= 1'b0;
      rdata_q     <= 8'h00;
`ifdef SRAM_ARB_AUTOINC_EN
      nextaddr_q  <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef SRAM_ARB_AUTOINC_EN
      nextaddr_q <= 1'b0;
`endif
      // Record edges that arrive outside IDLE so they survive the AVR slot.
      if (snes_fall_s && !snes_pend_q) begin
        snes_wr_q <= wr_fall_s;
      end
      snes_pend_q <= snes_pend_q | snes_fall_s;

      case (state_q)
        ST_IDLE: begin
          if (snes_req_s) begin
            state_q     <= ST_SNES;
            cnt_q       <= SNES_LAST;
            snes_pend_q <= 1'b0;
            mode_q      <= 1'b0;
            oe_n_q      <= snes_wr_s;
            we_n_q      <= ~snes_wr_s;
          end else if (AVR_REQ) begin
            state_q  <= ST_AVR;
            cnt_q    <= AVR_LAST;
            avr_we_q <= AVR_WE;
            dout_q   <= AVR_WDATA;
            mode_q   <= 1'b1;
            oe_n_q   <= AVR_WE;
            we_n_q   <= ~AVR_WE;
            doe_q    <= AVR_WE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SNES: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_GUARD;
            cnt_q   <= GUARD_LAST;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_AVR: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_GUARD;
            cnt_q   <= GUARD_LAST;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ack_q   <= 1'b1;
`ifdef SRAM_ARB_AUTOINC_EN
            nextaddr_q <= 1'b1;
`endif
            if (!avr_we_q) begin
              rdata_q <= SRAM_DIN;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_GUARD: begin
          // MODE and DOE are held through the guard gap, released in IDLE.
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            doe_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mode_q  <= 1'b0;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          doe_q   <= 1'b0;
        end
      endcase
    end
  end

  assign MODE      = mode_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_DOUT = dout_q;
  assign SRAM_DOE  = doe_q;
  assign AVR_ACK   = ack_q;
  assign AVR_RDATA = rdata_q;
`ifdef SRAM_ARB_AUTOINC_EN
  assign AVR_NEXTADDR_OUT = nextaddr_q;
`else
  assign AVR_NEXTADDR_OUT = 1'b0;
`endif

endmodule
